// File: rtl/game_input_conditioner_pkg.sv
// Shared speed and heart-rate code definitions for the game input conditioner.
package game_pkg;

   typedef enum logic [1:0] {
      SPD_STOP = 2'd0,
      SPD_SLOW = 2'd1,
      SPD_FAST = 2'd2
   } speed_t;

   localparam logic [2:0] HR_SLOW   = 3'b001;
   localparam logic [2:0] HR_FAST   = 3'b011;
   localparam logic [2:0] HR_STOP_A = 3'b111;
   localparam logic [2:0] HR_STOP_B = 3'b000;

   // Unlisted codes hold the current speed rather than forcing a stop.
   function automatic speed_t decode_speed(input logic [2:0] code, input speed_t cur);
      speed_t nxt;
      nxt = cur;
      case (code)
         HR_SLOW:              nxt = SPD_SLOW;
         HR_FAST:              nxt = SPD_FAST;
         HR_STOP_A, HR_STOP_B: nxt = SPD_STOP;
         default:              nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/game_input_conditioner_if.sv
// Raw pins in, conditioned levels/strobes/scroll tick out.
interface game_input_conditioner_if;
   import game_pkg::*;

   logic       jump_btn, down_btn, enable_btn, rst_btn;
   logic       heartrate1, heartrate2, heartrate3;
   logic       run;
   logic       jump_lvl, down_lvl;
   logic       jump_rise, enable_rise, rst_rise;
   logic [1:0] speed;
   logic       scroll_tick;

   modport master (
      output jump_btn, down_btn, enable_btn, rst_btn,
      output heartrate1, heartrate2, heartrate3, run,
      input  jump_lvl, down_lvl, jump_rise, enable_rise, rst_rise, speed, scroll_tick
   );

   modport slave (
      input  jump_btn, down_btn, enable_btn, rst_btn,
      input  heartrate1, heartrate2, heartrate3, run,
      output jump_lvl, down_lvl, jump_rise, enable_rise, rst_rise, speed, scroll_tick
   );

endinterface

// File: rtl/game_input_conditioner_debounce_sync.sv
// One pin: synchronizer chain, consecutive-cycle debounce, rising-edge strobe.
module debounce_sync #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic clr,
   input  logic pin,
   output logic lvl,
   output logic rise
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync <= '0;
         cnt  <= '0;
         lvl  <= 1'b0;
         rise <= 1'b0;
      end else begin
         sync[0] <= pin;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         rise <= 1'b0;
         if (s == lvl) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            lvl  <= s;
            rise <= s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/game_input_conditioner.sv
// Conditions raw game pins and turns the heart-rate code into a phase-accurate scroll tick.
module game_input_conditioner
   import game_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ACC_W           = 18
) (
   input logic                     clk,
   input logic                     clr,
   game_input_conditioner_if.slave pins
);

   // Bit order: 0 jump, 1 down, 2 enable, 3 rst, 4 hr1, 5 hr2, 6 hr3.
   logic [6:0] raw, lvl, rise;
   logic [2:0] hr_code;
   speed_t     speed_q, speed_d;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             tick;
   logic             unused_bits;

   assign raw = {pins.heartrate3, pins.heartrate2, pins.heartrate1,
                 pins.rst_btn, pins.enable_btn, pins.down_btn, pins.jump_btn};

   for (genvar g = 0; g < 7; g++) begin : g_pin
      debounce_sync #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk (clk),
         .clr (clr),
         .pin (raw[g]),
         .lvl (lvl[g]),
         .rise(rise[g])
      );
   end

   assign unused_bits = ^{rise[1], rise[6:4], lvl[3:2]};

   assign hr_code = {lvl[4], lvl[5], lvl[6]};

   always_comb begin
      speed_d = decode_speed(hr_code, speed_q);
   end

   // The carry out of the accumulator is the tick; acc is never cleared so phase survives speed/run changes.
   assign sum = {1'b0, acc} + (ACC_W+1)'(speed_q);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         speed_q <= SPD_STOP;
         acc     <= '0;
         tick    <= 1'b0;
      end else begin
         speed_q <= speed_d;
         if (pins.run && speed_q != SPD_STOP) begin
            acc  <= sum[ACC_W-1:0];
            tick <= sum[ACC_W];
         end else begin
            tick <= 1'b0;
         end
      end
   end

   assign pins.jump_lvl    = lvl[0];
   assign pins.down_lvl    = lvl[1];
   assign pins.jump_rise   = rise[0];
   assign pins.enable_rise = rise[2];
   assign pins.rst_rise    = rise[3];
   assign pins.speed       = speed_q;
   assign pins.scroll_tick = tick;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Bench for game_input_conditioner: directed table, corner sequences and random stimulus against a window-based model.
module tb_game_input_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int ACCW = 4;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   game_input_conditioner_if pins();

   game_input_conditioner #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .ACC_W          (ACCW)
   ) dut (
      .clk (clk),
      .clr (clr),
      .pins(pins)
   );

   // pin vector bit order: {hr3, hr2, hr1, rst, enable, down, jump}
   typedef struct {
      bit [6:0] pin;
      bit       run;
      int       cyc;
      bit       jl;
      bit       dl;
      int       spd;
      int       njr;
      int       ner;
      int       nrr;
      int       ntk;
   } vec_t;

   vec_t     tbl[$];
   bit [6:0] hist[$];
   bit [6:0] mq, mrise;
   int       mspeed, macc;
   bit       mtick;
   int       n_cmp, n_fail;
   int       cnt_jr, cnt_er, cnt_rr, cnt_tk;

   function automatic bit [6:0] cur_pins();
      return {pins.heartrate3, pins.heartrate2, pins.heartrate1,
              pins.rst_btn, pins.enable_btn, pins.down_btn, pins.jump_btn};
   endfunction

   function automatic bit [7:0] out_vec();
      return {pins.jump_lvl, pins.down_lvl, pins.jump_rise, pins.enable_rise,
              pins.rst_rise, pins.speed, pins.scroll_tick};
   endfunction

   // Synchronized sample seen by the debouncer at edge e (1-based since reset).
   function automatic bit s_at(int e, int i);
      if (e - SYNC < 1) return 1'b0;
      return hist[e-SYNC-1][i];
   endfunction

   task automatic model_reset();
      hist.delete();
      mq = '0; mrise = '0; mspeed = 0; macc = 0; mtick = 1'b0;
   endtask

   // A level flips once the last DEB synchronized samples all disagree with it.
   task automatic model_edge();
      int n;
      bit [2:0] code;
      bit [6:0] nq;
      bit flip;
      hist.push_back(cur_pins());
      n = hist.size();
      if (pins.run && mspeed != 0) begin
         macc  = macc + mspeed;
         mtick = (macc >= (1 << ACCW));
         macc  = macc % (1 << ACCW);
      end else begin
         mtick = 1'b0;
      end
      code = {mq[4], mq[5], mq[6]};
      if (code == 3'b001) mspeed = 1;
      else if (code == 3'b011) mspeed = 2;
      else if (code == 3'b111 || code == 3'b000) mspeed = 0;
      nq = mq;
      mrise = '0;
      for (int i = 0; i < 7; i++) begin
         flip = 1'b1;
         for (int k = 0; k < DEB; k++) if (s_at(n - k, i) == mq[i]) flip = 1'b0;
         if (flip) begin
            nq[i]    = ~mq[i];
            mrise[i] = nq[i];
         end
      end
      mq = nq;
   endtask

   task automatic chk(string name, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
      end
   endtask

   task automatic step();
      bit [7:0] want;
      @(posedge clk);
      if (clr) model_edge(); else model_reset();
      @(negedge clk);
      want = {mq[0], mq[1], mrise[0], mrise[2], mrise[3], 2'(mspeed), mtick};
      n_cmp++;
      if (out_vec() !== want) begin
         n_fail++;
         $display("FAIL model at %0t: got %b, want %b", $time, out_vec(), want);
      end
      cnt_jr += int'(pins.jump_rise);
      cnt_er += int'(pins.enable_rise);
      cnt_rr += int'(pins.rst_rise);
      cnt_tk += int'(pins.scroll_tick);
   endtask

   task automatic set_pins(bit [6:0] p);
      {pins.heartrate3, pins.heartrate2, pins.heartrate1,
       pins.rst_btn, pins.enable_btn, pins.down_btn, pins.jump_btn} = p;
   endtask

   task automatic set_clr(bit v);
      clr = v;
      if (!v) model_reset();
   endtask

   task automatic clear_counts();
      cnt_jr = 0; cnt_er = 0; cnt_rr = 0; cnt_tk = 0;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      clear_counts();
      model_reset();

      tbl.push_back('{7'b0000000, 1'b0,  6, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000001, 1'b0,  8, 1'b1, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{7'b0000001, 1'b0, 10, 1'b1, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000000, 1'b0,  8, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000100, 1'b0,  3, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000000, 1'b0, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000100, 1'b0,  4, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0000000, 1'b0, 10, 1'b0, 1'b0, 0, 0, 1, 0, 0});
      tbl.push_back('{7'b1000000, 1'b1, 40, 1'b0, 1'b0, 1, 0, 0, 0, 2});
      tbl.push_back('{7'b1100000, 1'b1, 40, 1'b0, 1'b0, 2, 0, 0, 0, 4});
      tbl.push_back('{7'b0100000, 1'b1, 12, 1'b0, 1'b0, 2, 0, 0, 0, 2});
      tbl.push_back('{7'b0100000, 1'b0, 20, 1'b0, 1'b0, 2, 0, 0, 0, 0});
      tbl.push_back('{7'b0100000, 1'b1, 10, 1'b0, 1'b0, 2, 0, 0, 0, 1});
      tbl.push_back('{7'b1110000, 1'b1, 20, 1'b0, 1'b0, 0, 0, 0, 0, 1});
      tbl.push_back('{7'b0100000, 1'b1, 12, 1'b0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0100010, 1'b1,  8, 1'b0, 1'b1, 0, 0, 0, 0, 0});
      tbl.push_back('{7'b0100000, 1'b1,  8, 1'b0, 1'b0, 0, 0, 0, 0, 0});

      // Reset held with every pin high, then release.
      set_pins(7'b1111111);
      pins.run = 1'b1;
      set_clr(1'b0);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("reset_hold", int'(out_vec()), 0);
      end
      set_clr(1'b1);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("post_release", int'(out_vec()), 0);
      end
      set_pins('0);
      pins.run = 1'b0;
      set_clr(1'b0);
      step(); step();
      set_clr(1'b1);

      foreach (tbl[r]) begin
         set_pins(tbl[r].pin);
         pins.run = tbl[r].run;
         clear_counts();
         for (int c = 0; c < tbl[r].cyc; c++) step();
         chk($sformatf("row%0d_jump_lvl", r), int'(pins.jump_lvl), int'(tbl[r].jl));
         chk($sformatf("row%0d_down_lvl", r), int'(pins.down_lvl), int'(tbl[r].dl));
         chk($sformatf("row%0d_speed", r), int'(pins.speed), tbl[r].spd);
         chk($sformatf("row%0d_jump_rises", r), cnt_jr, tbl[r].njr);
         chk($sformatf("row%0d_enable_rises", r), cnt_er, tbl[r].ner);
         chk($sformatf("row%0d_rst_rises", r), cnt_rr, tbl[r].nrr);
         chk($sformatf("row%0d_ticks", r), cnt_tk, tbl[r].ntk);
      end

      // Reset landing mid-debounce must discard the partial count.
      set_pins('0);
      pins.run = 1'b0;
      set_clr(1'b0);
      step(); step();
      set_clr(1'b1);
      pins.rst_btn = 1'b1;
      clear_counts();
      for (int c = 0; c < 4; c++) step();
      chk("rst_before_clr", cnt_rr, 0);
      set_clr(1'b0);
      step(); step();
      set_clr(1'b1);
      clear_counts();
      for (int c = 0; c < 5; c++) step();
      chk("rst_early_after_clr", cnt_rr, 0);
      step();
      chk("rst_rise_edge6", int'(pins.rst_rise), 1);
      for (int c = 0; c < 6; c++) step();
      chk("rst_rise_total", cnt_rr, 1);
      chk("rst_lvl_hold", int'(pins.rst_rise), 0);

      // Random pins and run, checked every cycle against the model.
      set_pins('0);
      set_clr(1'b0);
      step();
      set_clr(1'b1);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            bit [6:0] p;
            p = cur_pins();
            if ($urandom_range(0, 5) == 0) begin
               p[i] = ~p[i];
               set_pins(p);
            end
         end
         for (int i = 4; i < 7; i++) begin
            bit [6:0] p;
            p = cur_pins();
            if ($urandom_range(0, 19) == 0) begin
               p[i] = ~p[i];
               set_pins(p);
            end
         end
         if ($urandom_range(0, 49) == 0) pins.run = ~pins.run;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
